// File: rtl/ex_muldiv_seq_if.sv
// Execute-stage handshake between the pipeline control and the iterative mul/div sequencer.
// The master drives the operation request; the slave reports busy/stall/done and the result.
interface ex_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_Op1;
    logic [WIDTH-1:0] i_Op2;
    logic             i_flush;
    logic             i_hold;
    logic             o_busy;
    logic             o_stall_req;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_div_by_zero;

    modport master (
        output i_start, i_op, i_Op1, i_Op2, i_flush, i_hold,
        input  o_busy, o_stall_req, o_done, o_result, o_div_by_zero
    );

    modport slave (
        input  i_start, i_op, i_Op1, i_Op2, i_flush, i_hold,
        output o_busy, o_stall_req, o_done, o_result, o_div_by_zero
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative one-bit-per-cycle unsigned multiply (shift-add) / divide (restoring) sequencer.
// Stalls the front of the pipe for a fixed WIDTH+1 cycles and presents a registered result.
//
// state | meaning
// IDLE  | waiting for a mul/div op in EX
// RUN   | one iteration per cycle, cnt_q counts down from WIDTH
// DONE  | result valid; held while EX/MA is stalled
module ex_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           clk,
    input logic           reset,
    ex_muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q, acc_nxt;
    logic [WIDTH-1:0]   result_q;
    logic               dz_q;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               start_ok, last_iter;

    assign start_ok  = bus.i_start & ~bus.i_flush;
    assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(1));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    if (!bus.i_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.i_flush) state_nxt = IDLE;
    end

    // Divide keeps {remainder, quotient} in acc_q; the dividend shifts out of opa_q MSB-first.
    always_comb begin
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        acc_nxt  = acc_q;
        if (op_q[1]) begin
            if (!div_diff[WIDTH])
                acc_nxt = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else if (opb_q[0]) begin
            acc_nxt = acc_q + opa_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        op_q  <= bus.i_op;
                        opa_q <= {{WIDTH{1'b0}}, bus.i_Op1};
                        opb_q <= bus.i_Op2;
                        acc_q <= '0;
                        cnt_q <= CNT_W'(WIDTH);
                        dz_q  <= bus.i_op[1] & (bus.i_Op2 == '0);
                    end
                end
                RUN: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    opa_q <= opa_q << 1;
                    if (!op_q[1]) opb_q <= opb_q >> 1;
                    // MULHU/REMU take the upper half, MUL/DIVU the lower half.
                    if (last_iter && !bus.i_flush)
                        result_q <= op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_stall_req   = ((state_q == IDLE) & start_ok) | (state_q == RUN)
                             | ((state_q == DONE) & bus.i_hold);
    assign bus.o_done        = (state_q == DONE) & ~bus.i_flush;
    assign bus.o_div_by_zero = (state_q == DONE) & ~bus.i_flush & dz_q;
    assign bus.o_result      = result_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: vector table for results/latency, plus hold, flush and
// mid-operation reset sequences.
module tb_ex_muldiv_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    ex_muldiv_seq_if #(.WIDTH(W)) bus ();

    ex_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        bit          pulse;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          stall_cnt;
        int          lat;
        bit          seen;
        logic [31:0] res;
        logic        dz;
        stall_cnt = 0;
        lat       = -1;
        seen      = 0;
        res       = '0;
        dz        = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_op    = v.op;
        bus.i_Op1   = v.a;
        bus.i_Op2   = v.b;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.o_stall_req) stall_cnt++;
            if (bus.o_done) begin
                seen = 1;
                lat  = c;
                res  = bus.o_result;
                dz   = bus.o_div_by_zero;
            end else begin
                @(posedge clk); #1;
                if (v.pulse) bus.i_start = 1'b0;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " result"}, res, v.res);
        check({tag, " div_by_zero"}, {31'd0, dz}, {31'd0, v.dz});
        check({tag, " stall cycles"}, 32'(stall_cnt), 32'd33);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check({tag, " idle busy"}, {31'd0, bus.o_busy}, 32'd0);
        check({tag, " idle done"}, {31'd0, bus.o_done}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        int lat;
        bit seen;

        vecs[0]  = '{2'b00, 32'd7,        32'd6,        32'd42,         1'b0, 1'b1};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   1'b0, 1'b0};
        vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   1'b0, 1'b0};
        vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd14,         1'b0, 1'b0};
        vecs[4]  = '{2'b11, 32'd100,      32'd7,        32'd2,          1'b0, 1'b1};
        vecs[5]  = '{2'b10, 32'h1234,     32'd0,        32'hFFFFFFFF,   1'b1, 1'b0};
        vecs[6]  = '{2'b11, 32'h1234,     32'd0,        32'h00001234,   1'b1, 1'b0};
        vecs[7]  = '{2'b01, 32'h12345678, 32'h10,       32'h00000001,   1'b0, 1'b0};
        vecs[8]  = '{2'b00, 32'h12345678, 32'h10,       32'h23456780,   1'b0, 1'b0};
        vecs[9]  = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,   1'b0, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F,   1'b0, 1'b0};
        vecs[11] = '{2'b10, 32'd5,        32'd7,        32'd0,          1'b0, 1'b1};
        vecs[12] = '{2'b11, 32'd5,        32'd7,        32'd5,          1'b0, 1'b0};
        vecs[13] = '{2'b01, 32'h80000000, 32'd2,        32'h00000001,   1'b0, 1'b0};

        reset       = 1'b1;
        bus.i_start = 1'b0;
        bus.i_op    = 2'b00;
        bus.i_Op1   = '0;
        bus.i_Op2   = '0;
        bus.i_flush = 1'b0;
        bus.i_hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, bus.o_busy}, 32'd0);
        check("reset stall", {31'd0, bus.o_stall_req}, 32'd0);
        check("reset done", {31'd0, bus.o_done}, 32'd0);
        check("reset dz", {31'd0, bus.o_div_by_zero}, 32'd0);
        check("reset result", bus.o_result, 32'd0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Hold at DONE for three cycles, then release.
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_op    = 2'b00;
        bus.i_Op1   = 32'd3;
        bus.i_Op2   = 32'd5;
        bus.i_hold  = 1'b1;
        seen = 0;
        lat  = -1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.o_done) begin
                seen = 1;
                lat  = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("hold latency", 32'(lat), 32'd33);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("hold%0d done", k), {31'd0, bus.o_done}, 32'd1);
            check($sformatf("hold%0d result", k), bus.o_result, 32'd15);
            check($sformatf("hold%0d stall", k), {31'd0, bus.o_stall_req}, 32'd1);
            @(posedge clk); #1;
        end
        bus.i_hold = 1'b0;
        @(negedge clk);
        check("release done", {31'd0, bus.o_done}, 32'd1);
        check("release stall", {31'd0, bus.o_stall_req}, 32'd0);
        check("release result", bus.o_result, 32'd15);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("release idle", {31'd0, bus.o_busy}, 32'd0);

        // Flush at RUN cycle 10.
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_op    = 2'b01;
        bus.i_Op1   = 32'hFFFFFFFF;
        bus.i_Op2   = 32'hFFFFFFFF;
        repeat (10) @(posedge clk);
        #1;
        check("flush pre busy", {31'd0, bus.o_busy}, 32'd1);
        bus.i_flush = 1'b1;
        bus.i_start = 1'b0;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        @(negedge clk);
        check("flush busy", {31'd0, bus.o_busy}, 32'd0);
        check("flush stall", {31'd0, bus.o_stall_req}, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.o_done) done_cnt++;
        end
        check("flush done count", 32'(done_cnt), 32'd0);
        check("flush result kept", bus.o_result, 32'd15);

        // Reset mid-RUN, then a fresh DIVU.
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_op    = 2'b10;
        bus.i_Op1   = 32'd50;
        bus.i_Op2   = 32'd5;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset busy", {31'd0, bus.o_busy}, 32'd0);
        check("midreset stall", {31'd0, bus.o_stall_req}, 32'd0);
        check("midreset done", {31'd0, bus.o_done}, 32'd0);
        check("midreset result", bus.o_result, 32'd0);
        run_vec('{2'b10, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1}, "post-reset divu");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide sequencer attached to the execute stage, beside the single-cycle ALU.
- When a MUL/DIV-class instruction sits in EX, it accepts the forwarded operands (post operand-selection) and requests a pipeline stall from the stall unit.
- It runs a shift-add or restoring-divide loop, one bit per cycle, and presents the result for capture into EX/MA.
- Flush-aware, so a killed instruction never produces a result.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  EX holds a valid mul/div op (decode bit AND valid bit).
- i_op  in  2  00 MUL (low product), 01 MULHU (high unsigned product), 10 DIVU, 11 REMU.
- i_Op1  in  WIDTH  multiplicand/dividend (forwarded value).
- i_Op2  in  WIDTH  multiplier/divisor (forwarded value).
- i_flush  in  1  kill the in-flight op (branch mispredict / EXMA flush).
- i_hold  in  1  downstream stall (EXMA stall); result must be held.
- o_busy  out  1  FSM not IDLE.
- o_stall_req  out  1  stall IF/ID/IDEX and hold EX.
- o_done  out  1  result valid this cycle.
- o_result  out  WIDTH  result, registered.
- o_div_by_zero  out  1  valid with o_done; DIVU/REMU with i_Op2 == 0.

Behaviour:
- Reset (synchronous): state IDLE, counter 0, accumulators 0, o_result 0, o_done 0, o_div_by_zero 0, o_busy 0.
- States:
  - IDLE: on i_start & !i_flush, latch i_op, i_Op1, i_Op2, set counter = WIDTH, clear the 2*WIDTH accumulator, go to RUN.
  - RUN: one iteration per cycle, counter decrements; when counter reaches 1 (last iteration), go to DONE.
  - DONE: o_done = 1. If i_hold, stay in DONE. Otherwise go to IDLE.
- i_start is ignored in RUN and DONE. In DONE, EX holds the same instruction, which must not restart.
- Flush: i_flush in any state forces IDLE next cycle; o_done is never asserted for the killed op. Flush has priority over i_start and i_hold.
- o_stall_req, combinational: (IDLE & i_start & !i_flush) | RUN | (DONE & i_hold). It deasserts in the DONE cycle with !i_hold, so EX/MA captures o_result on that edge.
- Latency: start accepted at cycle 0, RUN covers cycles 1..WIDTH, DONE at cycle WIDTH+1. Stall is asserted WIDTH+1 cycles, fixed and independent of operand values.
- Multiply, unsigned shift-add: 2*WIDTH product register; each cycle add the multiplicand when the current multiplier LSB is 1, then shift. MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
- Divide, restoring, unsigned: each cycle shift {rem, quo} left by 1, trial-subtract the divisor; if no borrow, keep the difference and set quotient bit 1. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: the algorithm naturally yields quotient all-ones and remainder = dividend. o_div_by_zero = 1 with o_done; no early exit.
- o_result is loaded on the RUN->DONE transition and held stable until the next RUN->DONE transition. A flush does not clear it.
- o_done and o_div_by_zero are 0 outside DONE.
- Reset mid-operation: immediate return to reset values next edge; no stall persists.

Test Plan:
- MUL 7 x 6, i_start for 1 cycle:
  - o_stall_req high for cycles 0..32.
  - o_done high at cycle 33 with o_result = 42.
  - Back in IDLE at cycle 34.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> o_result = 0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; o_div_by_zero = 0.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF with o_div_by_zero = 1. REMU 0x1234 / 0 -> 0x00001234.
- Hold and flush:
  - Assert i_hold for 3 cycles at DONE: o_done and o_result are held and o_stall_req stays high; release -> IDLE.
  - Assert i_flush at RUN cycle 10: IDLE next cycle, o_stall_req drops, o_done is never asserted, o_result keeps its old value.
- Reset asserted mid-RUN, then a new i_start DIVU 9 / 3: outputs zeroed after reset; new result 3 at cycle 33 after the new start.
